usb_tx_sequencer: RTL and testbench
===================================

// Module: usb_tx_sequencer
// PURPOSE
// - Top-level TX control FSM. Sequences the packet compiler and serializer through SYNC/PID/DATA/CRC/EOP.
// - Accepts one transmit request from the protocol layer and drives c_state_TX to the compiler.
// - Pulls payload bytes from the TX buffer and reports completion or error.
// - Sits between the protocol/endpoint logic and the compiler/serializer datapath.
// PARAMETERS
// - MAX_PAYLOAD     64    largest legal DATA payload in bytes; larger lengths are an error
// - TIMEOUT_CYCLES  1024  watchdog limit per state (TX_TIMEOUT_EN builds only)
// PORTS
// - clk                 in   1  system clock
// - rst                 in   1  synchronous, active-high reset
// - tx_start            in   1  1-cycle request pulse; pID and Buffer_Occupancy sampled on this cycle
// - pID                 in   4  packet ID to send
// - Buffer_Occupancy    in   7  payload byte count in TX buffer
// - byte_sent           in   1  1-cycle pulse from serializer: current byte fully shifted out
// - eop_done            in   1  1-cycle pulse from serializer: EOP signalling finished
// - c_state_TX          out  3  state to compiler: 0 IDLE, 1 SYNC, 2 PID, 3 EOP, 4 DATA, 5 CRC
// - Get_TX_Packet_Data  out  1  1-cycle pop strobe to TX buffer
// - TX_Transfer_Active  out  1  high from the cycle after accept until the return to IDLE
// - tx_done             out  1  1-cycle pulse on a normal return to IDLE
// - TX_Error            out  1  1-cycle pulse on a rejected request or abort
// - bytes_left          out  7  payload bytes not yet sent
// BEHAVIOUR
// - Reset
//   - FSM=IDLE; c_state_TX=0; all strobes=0; TX_Transfer_Active=0; bytes_left=0.
//   - Reset mid-packet returns to IDLE on the next edge and emits no tx_done/TX_Error.
// - Accept (IDLE only)
//   - tx_start with pID in {0011 DATA0, 1011 DATA1}: latch len=Buffer_Occupancy.
//   - If len>MAX_PAYLOAD, pulse TX_Error next cycle and stay in IDLE.
//   - Otherwise go to SYNC next cycle.
//   - tx_start with pID in {0010 ACK, 1010 NAK, 1110 STALL}: go to SYNC.
//   - Any other pID: TX_Error pulse, stay in IDLE.
// - Busy
//   - tx_start while not IDLE is ignored; no error.
// - Transitions (all registered)
//   - SYNC -> PID on byte_sent.
//   - PID, handshake packet -> EOP on byte_sent.
//   - PID, data packet -> DATA on byte_sent if len>0, else -> CRC.
//   - DATA: each byte_sent decrements bytes_left; when bytes_left reaches 0, go to CRC.
//   - CRC: two byte_sent pulses (CRC16 lo, hi), then -> EOP.
//   - EOP -> IDLE on eop_done; tx_done pulses the same cycle FSM shows IDLE.
// - Payload fetch
//   - Get_TX_Packet_Data pulses on the cycle of the PID->DATA transition.
//   - It pulses again on each DATA byte_sent while bytes_left>1.
//   - Exactly len pops per packet; never any outside DATA.
// - Event handling
//   - byte_sent/eop_done in a state that does not consume them are ignored.
//   - Simultaneous byte_sent and eop_done: only the one the current state consumes acts.
// - Arithmetic
//   - bytes_left never wraps: decrement is gated at 0.
//   - CRC byte counter is 1 bit.
// CONFIGURATION
// - TX_TIMEOUT_EN defined
//   - 10-bit watchdog clears on every state change and every byte_sent.
//   - Reaching TIMEOUT_CYCLES in SYNC/PID/DATA/CRC/EOP forces IDLE and pulses TX_Error.
//   - No tx_done on timeout; remaining payload is not popped.
// - TX_TIMEOUT_EN undefined
//   - No watchdog; FSM waits indefinitely for serializer pulses.
// TESTING
// - ACK: tx_start pID=0010 -> c_state_TX 1,2,3,0 on successive byte_sent/byte_sent/eop_done; one tx_done; zero pops.
// - DATA0 len=4 -> states 1,2,4(x4 bytes),5(x2),3,0; exactly 4 Get_TX_Packet_Data pulses; bytes_left 4->0.
// - DATA1 len=0 -> PID goes straight to CRC (c_state_TX 2->5); zero pops; tx_done.
// - len=65 or pID=0001 -> TX_Error pulse, c_state_TX stays 0; tx_start during DATA -> ignored.
// - rst asserted in DATA with bytes_left=2 -> next cycle IDLE, outputs at reset values, no tx_done.
// - TX_TIMEOUT_EN: stall byte_sent in PID for 1024 cycles -> TX_Error pulse, c_state_TX=0.

Source files
------------

// File: rtl/usb_tx_sequencer_if.sv
// Request/serializer/compiler signal bundle for the USB TX sequencer.
// master: protocol side + serializer pulses; slave: the sequencer itself.
interface usb_tx_sequencer_if;
   localparam int unsigned PID_W   = 4;
   localparam int unsigned LEN_W   = 7;
   localparam int unsigned STATE_W = 3;

   logic               tx_start;
   logic [PID_W-1:0]   pID;
   logic [LEN_W-1:0]   Buffer_Occupancy;
   logic               byte_sent;
   logic               eop_done;
   logic [STATE_W-1:0] c_state_TX;
   logic               Get_TX_Packet_Data;
   logic               TX_Transfer_Active;
   logic               tx_done;
   logic               TX_Error;
   logic [LEN_W-1:0]   bytes_left;

   modport master (
      output tx_start, pID, Buffer_Occupancy, byte_sent, eop_done,
      input  c_state_TX, Get_TX_Packet_Data, TX_Transfer_Active, tx_done, TX_Error, bytes_left
   );

   modport slave (
      input  tx_start, pID, Buffer_Occupancy, byte_sent, eop_done,
      output c_state_TX, Get_TX_Packet_Data, TX_Transfer_Active, tx_done, TX_Error, bytes_left
   );
endinterface

// File: rtl/usb_tx_sequencer.sv
// USB TX control FSM: sequences SYNC/PID/DATA/CRC/EOP and pops payload bytes.
// Optional per-state watchdog enabled by defining TX_TIMEOUT_EN.
module usb_tx_sequencer #(
   parameter int unsigned MAX_PAYLOAD = 64
`ifdef TX_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input logic               clk,
   input logic               rst,
   usb_tx_sequencer_if.slave bus
);
   localparam int unsigned LEN_W = 7;
   localparam int unsigned PID_W = 4;

   localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
   localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;
   localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
   localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
   localparam logic [PID_W-1:0] PID_STALL = 4'b1110;

   // Encodings match the compiler's c_state_TX values so the register drives it directly.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      PID  = 3'd2,
      EOP  = 3'd3,
      DATA = 3'd4,
      CRC  = 3'd5
   } state_t;

   state_t           state, state_next;
   logic [LEN_W-1:0] bytes_left, bytes_left_next;
   logic             is_data, is_data_next;
   logic             crc_cnt, crc_cnt_next;
   logic             pop, pop_next;
   logic             done, done_next;
   logic             err, err_next;
   logic             active;
   logic             timeout_c;

`ifdef TX_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd;

   // Event in the current state takes priority over an expiring watchdog.
   assign timeout_c = (state != IDLE) && (wd == WD_LIMIT) && !bus.byte_sent &&
                      !((state == EOP) && bus.eop_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         wd <= '0;
      end else if ((state == IDLE) || (state_next != state) || bus.byte_sent) begin
         wd <= '0;
      end else begin
         wd <= wd + WD_W'(1);
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state and registered-output decode.
   always_comb begin
      state_next      = state;
      bytes_left_next = bytes_left;
      is_data_next    = is_data;
      crc_cnt_next    = crc_cnt;
      pop_next        = 1'b0;
      done_next       = 1'b0;
      err_next        = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.tx_start) begin
               if ((bus.pID == PID_DATA0) || (bus.pID == PID_DATA1)) begin
                  if (32'(bus.Buffer_Occupancy) > MAX_PAYLOAD) begin
                     err_next = 1'b1;
                  end else begin
                     state_next      = SYNC;
                     is_data_next    = 1'b1;
                     bytes_left_next = bus.Buffer_Occupancy;
                  end
               end else if ((bus.pID == PID_ACK) || (bus.pID == PID_NAK) ||
                            (bus.pID == PID_STALL)) begin
                  state_next      = SYNC;
                  is_data_next    = 1'b0;
                  bytes_left_next = '0;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         SYNC: begin
            if (bus.byte_sent) state_next = PID;
         end
         PID: begin
            if (bus.byte_sent) begin
               crc_cnt_next = 1'b0;
               if (!is_data) begin
                  state_next = EOP;
               end else if (bytes_left != '0) begin
                  state_next = DATA;
                  pop_next   = 1'b1;
               end else begin
                  state_next = CRC;
               end
            end
         end
         DATA: begin
            if (bus.byte_sent) begin
               if (bytes_left > LEN_W'(1)) pop_next = 1'b1;
               if (bytes_left != '0) bytes_left_next = bytes_left - LEN_W'(1);
               if (bytes_left <= LEN_W'(1)) begin
                  state_next   = CRC;
                  crc_cnt_next = 1'b0;
               end
            end
         end
         CRC: begin
            if (bus.byte_sent) begin
               if (crc_cnt) begin
                  state_next   = EOP;
                  crc_cnt_next = 1'b0;
               end else begin
                  crc_cnt_next = 1'b1;
               end
            end
         end
         EOP: begin
            if (bus.eop_done) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (timeout_c) begin
         state_next = IDLE;
         err_next   = 1'b1;
         done_next  = 1'b0;
         pop_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bytes_left <= '0;
         is_data    <= 1'b0;
         crc_cnt    <= 1'b0;
         pop        <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         active     <= 1'b0;
      end else begin
         state      <= state_next;
         bytes_left <= bytes_left_next;
         is_data    <= is_data_next;
         crc_cnt    <= crc_cnt_next;
         pop        <= pop_next;
         done       <= done_next;
         err        <= err_next;
         active     <= (state_next != IDLE);
      end
   end

   assign bus.c_state_TX         = state;
   assign bus.Get_TX_Packet_Data = pop;
   assign bus.TX_Transfer_Active = active;
   assign bus.tx_done            = done;
   assign bus.TX_Error           = err;
   assign bus.bytes_left         = bytes_left;
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: handshake, data, zero-length, reject, busy and reset cases.
module tb_usb_tx_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   pops = 0, dones = 0, errs = 0, pops_outside = 0;
   int   p0, d0, e0;

   usb_tx_sequencer_if bus ();

   usb_tx_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Pulse monitors; values seen at a rising edge are those held over the previous cycle.
   always @(posedge clk) begin
      if (bus.Get_TX_Packet_Data) pops <= pops + 1;
      if (bus.Get_TX_Packet_Data && bus.c_state_TX != 3'd4) pops_outside <= pops_outside + 1;
      if (bus.tx_done) dones <= dones + 1;
      if (bus.TX_Error) errs <= errs + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [3:0] pid, input logic [6:0] occ);
      bus.tx_start = 1'b1;
      bus.pID = pid;
      bus.Buffer_Occupancy = occ;
      tick();
      bus.tx_start = 1'b0;
   endtask

   task automatic byte_pulse();
      bus.byte_sent = 1'b1;
      tick();
      bus.byte_sent = 1'b0;
   endtask

   task automatic eop_pulse();
      bus.eop_done = 1'b1;
      tick();
      bus.eop_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.tx_start = 1'b0;
      bus.pID = 4'h0;
      bus.Buffer_Occupancy = 7'd0;
      bus.byte_sent = 1'b0;
      bus.eop_done = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_state", int'(bus.c_state_TX), 0);
      check("rst_active", int'(bus.TX_Transfer_Active), 0);
      check("rst_bytes_left", int'(bus.bytes_left), 0);
      check("rst_strobes", int'({bus.Get_TX_Packet_Data, bus.tx_done, bus.TX_Error}), 0);

      // ACK handshake: 1,2,3,0
      p0 = pops; d0 = dones; e0 = errs;
      start(4'b0010, 7'd9);
      check("ack_sync", int'(bus.c_state_TX), 1);
      check("ack_active", int'(bus.TX_Transfer_Active), 1);
      eop_pulse();
      check("ack_eop_in_sync_ignored", int'(bus.c_state_TX), 1);
      byte_pulse();
      check("ack_pid", int'(bus.c_state_TX), 2);
      byte_pulse();
      check("ack_eop", int'(bus.c_state_TX), 3);
      byte_pulse();
      check("ack_byte_in_eop_ignored", int'(bus.c_state_TX), 3);
      eop_pulse();
      check("ack_idle", int'(bus.c_state_TX), 0);
      check("ack_done_pulse", int'(bus.tx_done), 1);
      check("ack_inactive", int'(bus.TX_Transfer_Active), 0);
      tick();
      check("ack_done_cleared", int'(bus.tx_done), 0);
      tick();
      check("ack_done_count", dones - d0, 1);
      check("ack_pops", pops - p0, 0);
      check("ack_errs", errs - e0, 0);

      // DATA0 len=4
      p0 = pops; d0 = dones;
      start(4'b0011, 7'd4);
      check("d0_sync", int'(bus.c_state_TX), 1);
      byte_pulse();
      check("d0_pid", int'(bus.c_state_TX), 2);
      byte_pulse();
      check("d0_data", int'(bus.c_state_TX), 4);
      check("d0_first_pop", int'(bus.Get_TX_Packet_Data), 1);
      check("d0_bl4", int'(bus.bytes_left), 4);
      for (int i = 3; i >= 0; i--) begin
         byte_pulse();
         check("d0_bl", int'(bus.bytes_left), i);
         check("d0_state", int'(bus.c_state_TX), (i == 0) ? 5 : 4);
      end
      byte_pulse();
      check("d0_crc_lo", int'(bus.c_state_TX), 5);
      byte_pulse();
      check("d0_crc_to_eop", int'(bus.c_state_TX), 3);
      eop_pulse();
      check("d0_idle", int'(bus.c_state_TX), 0);
      check("d0_done", int'(bus.tx_done), 1);
      repeat (2) tick();
      check("d0_pops", pops - p0, 4);
      check("d0_done_count", dones - d0, 1);

      // DATA1 len=0: PID straight to CRC
      p0 = pops; d0 = dones;
      start(4'b1011, 7'd0);
      byte_pulse();
      check("z_pid", int'(bus.c_state_TX), 2);
      byte_pulse();
      check("z_crc", int'(bus.c_state_TX), 5);
      byte_pulse();
      byte_pulse();
      check("z_eop", int'(bus.c_state_TX), 3);
      eop_pulse();
      check("z_idle", int'(bus.c_state_TX), 0);
      repeat (2) tick();
      check("z_pops", pops - p0, 0);
      check("z_done_count", dones - d0, 1);

      // Rejects: oversize length, unknown pID
      e0 = errs;
      start(4'b0011, 7'd65);
      check("big_err", int'(bus.TX_Error), 1);
      check("big_state", int'(bus.c_state_TX), 0);
      tick();
      check("big_err_cleared", int'(bus.TX_Error), 0);
      start(4'b0001, 7'd1);
      check("pid_err", int'(bus.TX_Error), 1);
      check("pid_state", int'(bus.c_state_TX), 0);
      tick();
      check("err_count", errs - e0, 2);

      // DATA1 len=3: busy tx_start ignored, eop_done in DATA ignored
      p0 = pops; e0 = errs;
      start(4'b1011, 7'd3);
      byte_pulse();
      byte_pulse();
      check("b_data", int'(bus.c_state_TX), 4);
      start(4'b0010, 7'd0);
      check("b_busy_state", int'(bus.c_state_TX), 4);
      check("b_busy_noerr", int'(bus.TX_Error), 0);
      check("b_busy_bl", int'(bus.bytes_left), 3);
      bus.eop_done = 1'b1;
      byte_pulse();
      bus.eop_done = 1'b0;
      check("b_both_bl", int'(bus.bytes_left), 2);
      check("b_both_state", int'(bus.c_state_TX), 4);
      byte_pulse();
      byte_pulse();
      check("b_crc", int'(bus.c_state_TX), 5);
      byte_pulse();
      byte_pulse();
      eop_pulse();
      check("b_idle", int'(bus.c_state_TX), 0);
      repeat (2) tick();
      check("b_pops", pops - p0, 3);
      check("b_errs", errs - e0, 0);

      // DATA0 len=64 (accepted), reset with bytes_left=2
      p0 = pops; d0 = dones; e0 = errs;
      start(4'b0011, 7'd64);
      check("max_sync", int'(bus.c_state_TX), 1);
      byte_pulse();
      byte_pulse();
      for (int i = 0; i < 62; i++) byte_pulse();
      check("r_pre_bl", int'(bus.bytes_left), 2);
      check("r_pre_state", int'(bus.c_state_TX), 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r_state", int'(bus.c_state_TX), 0);
      check("r_bl", int'(bus.bytes_left), 0);
      check("r_active", int'(bus.TX_Transfer_Active), 0);
      check("r_strobes", int'({bus.Get_TX_Packet_Data, bus.tx_done, bus.TX_Error}), 0);
      repeat (2) tick();
      check("r_no_done", dones - d0, 0);
      check("r_no_err", errs - e0, 0);
      check("r_pops", pops - p0, 63);

`ifdef TX_TIMEOUT_EN
      // Stall in PID until the watchdog fires
      d0 = dones;
      start(4'b0010, 7'd0);
      byte_pulse();
      check("to_pid", int'(bus.c_state_TX), 2);
      repeat (1023) tick();
      check("to_still_pid", int'(bus.c_state_TX), 2);
      tick();
      check("to_idle", int'(bus.c_state_TX), 0);
      check("to_err", int'(bus.TX_Error), 1);
      repeat (2) tick();
      check("to_no_done", dones - d0, 0);
`endif

      check("no_pop_outside_data", pops_outside, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
